// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - writeback register, 15x32 register file, PC (R15) and two read ports
// Optional read bypass from the writeback register: define REGFILE_WB_BYPASS_EN.
module regfile_writeback #(
  parameter int          DATA_W   = 32,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  input  logic [3:0]        rd_addr_a,
  input  logic [3:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] pc,
  output logic              wb_pending
);

  logic [DATA_W-1:0] regs_q [0:14];
  logic [DATA_W-1:0] regs_d [0:14];
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [3:0]        pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic              commit_pc;

  always_comb begin
    regs_d       = regs_q;
    pc_d         = pc_q;
    pend_valid_d = 1'b0;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    commit_pc    = pend_valid_q && (pend_addr_q == 4'hF);

    if (pend_valid_q && !commit_pc)
      regs_d[pend_addr_q] = pend_data_q;

    // An R15 commit outranks both a branch and a stall.
    if (commit_pc)
      pc_d = {pend_data_q[DATA_W-1:2], 2'b00};
    else if (branch_taken && !stall)
      pc_d = {branch_target[DATA_W-1:2], 2'b00};
    else if (!stall)
      pc_d = pc_q + 32'd4;

    if (!stall) begin
      pend_valid_d = wb_en;
      pend_addr_d  = wb_addr;
      pend_data_d  = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++)
        regs_q[i] <= '0;
      pc_q         <= PC_RESET;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
    end else begin
      regs_q       <= regs_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] addr);
    logic [DATA_W-1:0] val;
    if (addr == 4'hF)
      val = pc_q + 32'd8;
`ifdef REGFILE_WB_BYPASS_EN
    else if (pend_valid_q && (pend_addr_q == addr))
      val = pend_data_q;
`endif
    else
      val = regs_q[addr];
    return val;
  endfunction

  always_comb begin
    rd_data_a = read_port(rd_addr_a);
    rd_data_b = read_port(rd_addr_b);
  end

  assign pc         = pc_q;
  assign wb_pending = pend_valid_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed self-checking bench for regfile_writeback
// Expected read-bypass values follow REGFILE_WB_BYPASS_EN when it is defined.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [31:0] pc;
  logic        wb_pending;

  int total = 0;
  int bad   = 0;

  regfile_writeback #(.DATA_W(32), .PC_RESET(32'h0000_0100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .pc           (pc),
    .wb_pending   (wb_pending)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    #1;
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; wb_en = 1'b0; wb_addr = 4'd0; wb_data = 32'd0;
    branch_taken = 1'b0; branch_target = 32'd0; rd_addr_a = 4'd3; rd_addr_b = 4'd15;
    tick; tick;
    check("reset_pc",      pc,                 32'h0000_0100);
    check("reset_rd_a3",   rd_data_a,          32'h0);
    check("reset_rd_b15",  rd_data_b,          32'h0000_0108);
    check("reset_pending", 32'(wb_pending),    32'h0);

    rst_n = 1'b1;
    wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'hDEAD_BEEF; rd_addr_a = 4'd5;
    check("no_input_fwd",  rd_data_a,          32'h0);
    tick;
    wb_en = 1'b0;
    check("wr_pending",    32'(wb_pending),    32'h1);
    check("wr_pc_adv",     pc,                 32'h0000_0104);
`ifdef REGFILE_WB_BYPASS_EN
    check("wr_bypass",     rd_data_a,          32'hDEAD_BEEF);
`else
    check("wr_no_bypass",  rd_data_a,          32'h0);
`endif
    tick;
    check("wr_committed",  rd_data_a,          32'hDEAD_BEEF);
    check("wr_pend_clr",   32'(wb_pending),    32'h0);
    check("wr_pc_108",     pc,                 32'h0000_0108);

    wb_en = 1'b1; wb_addr = 4'd15; wb_data = 32'h0000_2003;
    tick;
    wb_en = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0400;
    check("r15_pc_pre",    pc,                 32'h0000_010C);
    tick;
    check("r15_over_br",   pc,                 32'h0000_2000);
    check("r15_read",      rd_data_b,          32'h0000_2008);

    branch_target = 32'h0000_0043;
    tick;
    branch_taken = 1'b0;
    check("branch_align",  pc,                 32'h0000_0040);

    stall = 1'b1; wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'd7; rd_addr_a = 4'd2;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("stall_pc",    pc,                 32'h0000_0040);
      check("stall_nopend", 32'(wb_pending),   32'h0);
    end
    stall = 1'b0; wb_en = 1'b0;
    tick;
    check("unstall_pc",    pc,                 32'h0000_0044);
    tick;
    check("stall_dropped", rd_data_a,          32'h0);

    branch_taken = 1'b1; branch_target = 32'hFFFF_FFF8;
    tick;
    branch_taken = 1'b0;
    check("wrap_pc0",      pc,                 32'hFFFF_FFF8);
    tick;
    check("wrap_pc1",      pc,                 32'hFFFF_FFFC);
    check("wrap_rd15",     rd_data_b,          32'h0000_0004);
    tick;
    check("wrap_pc2",      pc,                 32'h0000_0000);

    wb_en = 1'b1; wb_addr = 4'd7; wb_data = 32'h11; rd_addr_a = 4'd7;
    tick;
    wb_data = 32'h22;
    tick;
    wb_en = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
    check("b2b_mid",       rd_data_a,          32'h22);
`else
    check("b2b_mid",       rd_data_a,          32'h11);
`endif
    tick;
    check("b2b_last",      rd_data_a,          32'h22);

    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'hAB; rd_addr_a = 4'd3;
    tick;
    wb_en = 1'b0; stall = 1'b1;
    tick;
    stall = 1'b0;
    check("stall_commit",  rd_data_a,          32'hAB);
    check("stall_cm_pend", 32'(wb_pending),    32'h0);

    wb_en = 1'b1; wb_addr = 4'd9; wb_data = 32'h55; rd_addr_a = 4'd9; rd_addr_b = 4'd5;
    tick;
    wb_en = 1'b0; rst_n = 1'b0;
    tick;
    check("rst_mid_r9",    rd_data_a,          32'h0);
    check("rst_mid_pend",  32'(wb_pending),    32'h0);
    check("rst_mid_r5",    rd_data_b,          32'h0);
    check("rst_mid_pc",    pc,                 32'h0000_0100);
    rst_n = 1'b1;
    tick;
    check("rst_mid_r9_b",  rd_data_a,          32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
